rst_sequencer: RTL

Sequences reset release for the saumauping SoC. It takes the board-level asynchronous reset and produces a set of staged, synchronously released reset outputs, one per subsystem (interconnect first, then cores, then peripherals). It also accepts a software reset request over a req/ack handshake and records the cause of the last reset. It sits directly behind the SoC's top-level `clk`/`rst_n` pins and drives every internal reset.

---
 rtl/rst_seq_pkg.sv | 25 ++
 rtl/rst_sync.sv | 34 +++
 rtl/rst_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
// Shared definitions for the reset sequencer: the sequencer state encoding,
// the reset-cause codes reported on rst_cause, and a small helper used to
// size the shared hold/gap counter.
// Ports: none (package).
package rst_seq_pkg;

    // Sequencer states: all resets held, staged release in progress, running.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Cause of the most recent reset as reported on rst_cause.
    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // Larger of two counts; the hold and gap phases share one counter.
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync
// Two-flop reset synchroniser. The output asserts asynchronously with the
// input reset and deasserts on the second clock edge after release.
// Reusable wherever a local synchronously released reset is needed.
// Ports:
//   i_clk        clock of the destination domain
//   i_rst_n      asynchronous active-low reset in
//   o_rst_sync_n active-low reset, synchronously released
module rst_sync
    import rst_seq_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_sync_n
);

    logic r_meta;
    logic r_sync;

    // A constant 1 ripples through two flops once the pin reset is released,
    // so the metastable first stage never reaches the output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end

    assign o_rst_sync_n = r_sync;

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer
// Staged reset release for the SoC. The board reset is synchronised, all
// subsystem resets are held for HOLD_CYCLES, then released one stage at a
// time STAGE_GAP cycles apart (interconnect, cores, peripherals). A software
// reset request accepted while running restarts the sequence, and the cause
// of the last reset is reported.
// Optional feature: define RST_SEQ_WDT_EN to build a watchdog that forces a
// reset after WDT_CYCLES running cycles without a wdt_kick.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low board reset
//   sw_rst_req  software reset request (level)
//   wdt_kick    watchdog restart pulse (unused without the watchdog)
//   sw_rst_ack  one-cycle acknowledge of an accepted request
//   rst_out_n   staged active-low resets, released in index order
//   rst_done    high once every stage is released
//   rst_cause   00 pin/power-on, 01 software, 10 watchdog
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYCLES = 30,
    parameter int STAGE_GAP   = 8,
    parameter int WDT_CYCLES  = 30000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sw_rst_req,
    input  logic                wdt_kick,
    output logic                sw_rst_ack,
    output logic [N_STAGES-1:0] rst_out_n,
    output logic                rst_done,
    output logic [1:0]          rst_cause
);

    localparam int CNT_MAX = maxInt(HOLD_CYCLES, STAGE_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    logic                w_rst_sync_n;
    logic                w_wdt_expire;
    logic                w_sw_accept;
    logic [N_STAGES-1:0] w_next_stages;
    logic [CNT_W-1:0]    w_cnt_inc;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_STAGES-1:0] r_rst_out_n;
    logic                r_done;
    logic                r_ack;
    logic [1:0]          r_cause;

    rst_sync u_rst_sync (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_rst_sync_n (w_rst_sync_n)
    );

    // Releasing a stage shifts one more 1 in from the bottom.
    assign w_next_stages = (r_rst_out_n << 1) | N_STAGES'(1);

    // Saturating increment: the counter never wraps.
    assign w_cnt_inc = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : r_cnt + 1'b1;

`ifdef RST_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES) + 1;

    logic [WDT_W-1:0] r_wdt;

    // Expires on the WDT_CYCLES-th unkicked edge in RUN.
    assign w_wdt_expire = (r_state == ST_RUN) && !wdt_kick &&
                          (r_wdt == WDT_W'(WDT_CYCLES - 1));

    // Held at zero outside RUN, so it always starts clear on entry to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt <= '0;
        end else if (!w_rst_sync_n || (r_state != ST_RUN) || wdt_kick) begin
            r_wdt <= '0;
        end else if (r_wdt != WDT_W'(WDT_CYCLES)) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_wdt_expire = 1'b0;
    assign w_unused     = wdt_kick ^ (WDT_CYCLES == 0);
`endif

    // The watchdog wins a tie with a software request: no ack is given.
    assign w_sw_accept = (r_state == ST_RUN) && sw_rst_req && !w_wdt_expire;

    // The pin reset clears everything at once; the synchronised reset then
    // keeps the sequencer parked until it releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_rst_out_n <= '0;
            r_done      <= 1'b0;
            r_ack       <= 1'b0;
            r_cause     <= CAUSE_POR;
        end else if (!w_rst_sync_n) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_rst_out_n <= '0;
            r_done      <= 1'b0;
            r_ack       <= 1'b0;
            r_cause     <= CAUSE_POR;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        r_cnt       <= '0;
                        r_rst_out_n <= w_next_stages;
                        if (&w_next_stages) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
                        r_cnt       <= '0;
                        r_rst_out_n <= w_next_stages;
                        if (&w_next_stages) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (w_wdt_expire || w_sw_accept) begin
                        r_state     <= ST_HOLD;
                        r_cnt       <= '0;
                        r_rst_out_n <= '0;
                        r_done      <= 1'b0;
                        r_ack       <= w_sw_accept;
                        r_cause     <= w_wdt_expire ? CAUSE_WDT : CAUSE_SW;
                    end
                end
                default: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign sw_rst_ack = r_ack;
    assign rst_out_n  = r_rst_out_n;
    assign rst_done   = r_done;
    assign rst_cause  = r_cause;

endmodule
